helo_scroll_display: RTL and testbench

//  Drives NUM_DIGITS active-low seven-segment digits from a MSG_LEN-entry message buffer of 3-bit char codes.

---
 rtl/helo_pkg.sv | 43 ++++
 rtl/helo_char_seg.sv | 23 ++
 rtl/helo_scroll_display.sv | 135 +++++++++++++
 tb/tb_helo_scroll_display.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/helo_pkg.sv
// Shared types and constants for the HELO scrolling message display.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package helo_pkg;

    typedef logic [2:0] char_t;

    localparam char_t CH_H     = 3'd0;
    localparam char_t CH_E     = 3'd1;
    localparam char_t CH_L     = 3'd2;
    localparam char_t CH_O     = 3'd3;
    localparam char_t CH_BLANK = 3'd4;   // any code with bit 2 set is blank

    typedef enum logic {IDLE, RUN} state_t;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_STATIC   = 2'b00;
    localparam mode_t MODE_SCROLL_L = 2'b01;
    localparam mode_t MODE_BLINK    = 2'b10;
    localparam mode_t MODE_SCROLL_R = 2'b11;

    // Segment patterns, bit order g..a, active-low.
    localparam logic [6:0] SEG_H     = 7'b0001001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_O     = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Power-up message: H,E,L,L,O followed by blanks.
    function automatic char_t reset_char(input int idx);
        char_t c;
        case (idx)
            0:       c = CH_H;
            1:       c = CH_E;
            2, 3:    c = CH_L;
            4:       c = CH_O;
            default: c = CH_BLANK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/helo_char_seg.sv
// Char code to seven-segment decoder (g..a, active-low).
// Latency: combinational, zero cycles.
// Backpressure: none; output follows input.
// Ports: char_i - 3-bit char code; seg_o - 7-bit segment pattern.
module helo_char_seg
    import helo_pkg::*;
(
    input  char_t       char_i,
    output logic [6:0]  seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (char_i)
            CH_H:    seg_o = SEG_H;
            CH_E:    seg_o = SEG_E;
            CH_L:    seg_o = SEG_L;
            CH_O:    seg_o = SEG_O;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/helo_scroll_display.sv
// Multi-digit animated message display: static, scroll left/right, blink.
// Latency: hex_o is registered, one cycle behind buffer/pointer/phase state.
// Backpressure: none; load strobes always accepted, enable_i freezes animation.
// Ports: clk_i, rst_i (async high), enable_i, mode_i, load_i, load_index_i,
//        load_char_i -> hex_o (7 bits per digit, digit d at [7*d +: 7]), wrap_o.
module helo_scroll_display
    import helo_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int MSG_LEN    = 8,
    parameter int TICK_DIV   = 50000000
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        enable_i,
    input  logic [1:0]                  mode_i,
    input  logic                        load_i,
    input  logic [$clog2(MSG_LEN)-1:0]  load_index_i,
    input  logic [2:0]                  load_char_i,
    output logic [7*NUM_DIGITS-1:0]     hex_o,
    output logic                        wrap_o
);

    localparam int IDX_W = $clog2(MSG_LEN);
    localparam int SUM_W = IDX_W + 1;
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(MSG_LEN - 1);

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]         ptr_q, ptr_d;
    logic                     phase_q, phase_d;   // 1 = visible
    logic                     wrap_q, wrap_d;
    char_t                    msg_q [MSG_LEN];
    logic [7*NUM_DIGITS-1:0]  hex_q, hex_d;
    logic                     tick;
    logic                     blank_all;
    logic                     load_ok;

    // Out-of-range addresses only exist when MSG_LEN is not a power of two.
    assign load_ok = (32'(load_index_i) < MSG_LEN);

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        ptr_d   = ptr_q;
        phase_d = phase_q;
        wrap_d  = 1'b0;
        tick    = 1'b0;

        case (state_q)
            IDLE:    if (enable_i)  state_d = RUN;
            RUN:     if (!enable_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Gating with enable_i means the cycle Enable drops can never tick.
        if (state_q == RUN && enable_i) begin
            tick  = (cnt_q == CNT_LAST);
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end

        if (tick) begin
            case (mode_i)
                MODE_SCROLL_L: begin
                    if (ptr_q == PTR_LAST) begin
                        ptr_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
                MODE_SCROLL_R: begin
                    if (ptr_q == '0) begin
                        ptr_d  = PTR_LAST;
                        wrap_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q - 1'b1;
                    end
                end
                MODE_BLINK: phase_d = ~phase_q;
                default:    ;
            endcase
        end

        if (mode_i != MODE_BLINK) phase_d = 1'b1;
    end

    // The stored phase only matters while blinking, so leaving BLINK
    // unblanks the display on the very next edge.
    assign blank_all = (mode_i == MODE_BLINK) && !phase_q;

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
        logic [SUM_W-1:0] sum;
        char_t            ch;

        // ptr < MSG_LEN and offset < NUM_DIGITS <= MSG_LEN, so one
        // conditional subtract is a complete modulo.
        always_comb begin
            sum = {1'b0, ptr_q} + SUM_W'(NUM_DIGITS - 1 - d);
            if (sum >= SUM_W'(MSG_LEN)) sum = sum - SUM_W'(MSG_LEN);
            ch = blank_all ? CH_BLANK : msg_q[sum[IDX_W-1:0]];
        end

        helo_char_seg u_seg (
            .char_i (ch),
            .seg_o  (hex_d[7*d +: 7])
        );
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            phase_q <= 1'b1;
            wrap_q  <= 1'b0;
            hex_q   <= '1;
            for (int i = 0; i < MSG_LEN; i++) msg_q[i] <= reset_char(i);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            phase_q <= phase_d;
            wrap_q  <= wrap_d;
            hex_q   <= hex_d;
            if (load_i && load_ok) msg_q[load_index_i] <= load_char_i;
        end
    end

    assign hex_o  = hex_q;
    assign wrap_o = wrap_q;

endmodule

// File: tb/tb_helo_scroll_display.sv
module tb_helo_scroll_display;

    localparam int ND = 4;
    localparam int ML = 8;
    localparam int TD = 4;

    localparam logic [6:0] S_H = 7'h09;
    localparam logic [6:0] S_E = 7'h06;
    localparam logic [6:0] S_L = 7'h47;
    localparam logic [6:0] S_O = 7'h40;
    localparam logic [6:0] S_B = 7'h7F;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        load = 1'b0;
    logic [2:0]  load_index = 3'd0;
    logic [2:0]  load_char = 3'd0;
    logic [27:0] hex;
    logic        wrap;

    int checks = 0;
    int errors = 0;

    // Reference model: message array, window start, visibility, run age.
    int          m_buf [ML];
    int          m_ptr;
    bit          m_vis;
    bit          m_running;
    int          m_age;
    logic [27:0] exp_hex;
    logic        exp_wrap;

    logic [27:0] w_hell;
    logic [27:0] w_ello;
    logic [27:0] w_llob;
    logic [27:0] w_bhel;
    logic [27:0] w_ollo;

    helo_scroll_display #(
        .NUM_DIGITS (ND),
        .MSG_LEN    (ML),
        .TICK_DIV   (TD)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .enable_i     (enable),
        .mode_i       (mode),
        .load_i       (load),
        .load_index_i (load_index),
        .load_char_i  (load_char),
        .hex_o        (hex),
        .wrap_o       (wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int c);
        case (c)
            0:       return S_H;
            1:       return S_E;
            2:       return S_L;
            3:       return S_O;
            default: return S_B;
        endcase
    endfunction

    function automatic logic [27:0] render(input bit vis_now);
        logic [27:0] h;
        h = '1;
        for (int d = 0; d < ND; d++)
            h[7*d +: 7] = vis_now ? seg_of(m_buf[(m_ptr + ND - 1 - d) % ML]) : S_B;
        return h;
    endfunction

    function automatic void model_reset();
        string init;
        init = "HELLO";
        for (int i = 0; i < ML; i++) m_buf[i] = 4;
        m_buf[0] = 0; m_buf[1] = 1; m_buf[2] = 2; m_buf[3] = 2; m_buf[4] = 3;
        m_ptr = 0; m_vis = 1'b1; m_running = 1'b0; m_age = 0;
        exp_hex = '1; exp_wrap = 1'b0;
    endfunction

    // One rising edge of the reference: display shows pre-edge state,
    // ticks arrive every TD-th edge of uninterrupted running.
    function automatic void model_edge();
        bit tick;
        tick = 1'b0;
        exp_wrap = 1'b0;
        exp_hex = render(m_vis || mode != 2'b10);
        if (m_running && enable) begin
            m_age++;
            tick = (m_age % TD == 0);
        end else begin
            m_age = 0;
        end
        m_running = enable;
        if (tick) begin
            case (mode)
                2'b01: begin exp_wrap = (m_ptr == ML - 1); m_ptr = (m_ptr + 1) % ML; end
                2'b11: begin exp_wrap = (m_ptr == 0); m_ptr = (m_ptr + ML - 1) % ML; end
                2'b10: m_vis = !m_vis;
                default: ;
            endcase
        end
        if (mode != 2'b10) m_vis = 1'b1;
        if (load && int'(load_index) < ML) m_buf[load_index] = int'(load_char);
    endfunction

    task automatic clk_step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        load = 1'b0;
        enable = 1'b0;
        mode = 2'b00;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        enable = 1'b0; mode = 2'b00; load = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (hex !== 28'hFFFFFFF || wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_async hex=%h wrap=%b expected hex=fffffff wrap=0", hex, wrap);
        end
        @(posedge clk); #1;
        checks++;
        if (hex !== 28'hFFFFFFF || wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_held hex=%h wrap=%b expected hex=fffffff wrap=0", hex, wrap);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        clk_step();
        checks++;
        if (hex !== w_hell || wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_release hex=%h wrap=%b expected hex=%h wrap=0", hex, wrap, w_hell);
        end
    endtask

    task automatic test_scroll_left();
        int  wraps;
        bit  prev_wrap;
        apply_reset();
        mode = 2'b01; enable = 1'b1;
        wraps = 0; prev_wrap = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            clk_step();
            checks++;
            if (hex !== exp_hex || wrap !== exp_wrap) begin
                errors++;
                $display("FAIL scroll_l cyc%0d hex=%h wrap=%b expected hex=%h wrap=%b", i, hex, wrap, exp_hex, exp_wrap);
            end
            if (i == 6) begin
                checks++;
                if (hex !== w_ello) begin
                    errors++;
                    $display("FAIL scroll_l_tick1 hex=%h expected %h", hex, w_ello);
                end
            end
            if (i == 10) begin
                checks++;
                if (hex !== w_llob) begin
                    errors++;
                    $display("FAIL scroll_l_tick2 hex=%h expected %h", hex, w_llob);
                end
            end
            if (prev_wrap) begin
                checks++;
                if (hex !== w_hell || wrap !== 1'b0) begin
                    errors++;
                    $display("FAIL scroll_l_after_wrap hex=%h wrap=%b expected hex=%h wrap=0", hex, wrap, w_hell);
                end
            end
            if (wrap === 1'b1) wraps++;
            prev_wrap = (wrap === 1'b1);
        end
        checks++;
        if (wraps != 1) begin
            errors++;
            $display("FAIL scroll_l_wrap_count got %0d expected 1", wraps);
        end
    endtask

    task automatic test_scroll_right();
        apply_reset();
        mode = 2'b11; enable = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            clk_step();
            checks++;
            if (hex !== exp_hex || wrap !== exp_wrap) begin
                errors++;
                $display("FAIL scroll_r cyc%0d hex=%h wrap=%b expected hex=%h wrap=%b", i, hex, wrap, exp_hex, exp_wrap);
            end
            if (i == 5) begin
                checks++;
                if (wrap !== 1'b1) begin
                    errors++;
                    $display("FAIL scroll_r_wrap wrap=%b expected 1", wrap);
                end
            end
            if (i == 6) begin
                checks++;
                if (hex !== w_bhel || wrap !== 1'b0) begin
                    errors++;
                    $display("FAIL scroll_r_window hex=%h wrap=%b expected hex=%h wrap=0", hex, wrap, w_bhel);
                end
            end
        end
    endtask

    task automatic test_blink();
        apply_reset();
        mode = 2'b10; enable = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            clk_step();
            checks++;
            if (hex !== exp_hex || wrap !== exp_wrap) begin
                errors++;
                $display("FAIL blink cyc%0d hex=%h wrap=%b expected hex=%h wrap=%b", i, hex, wrap, exp_hex, exp_wrap);
            end
            if (i == 6 || i == 14) begin
                checks++;
                if (hex !== 28'hFFFFFFF) begin
                    errors++;
                    $display("FAIL blink_off cyc%0d hex=%h expected fffffff", i, hex);
                end
            end
            if (i == 10) begin
                checks++;
                if (hex !== w_hell) begin
                    errors++;
                    $display("FAIL blink_on hex=%h expected %h", hex, w_hell);
                end
            end
        end
        mode = 2'b00;
        clk_step();
        checks++;
        if (hex !== w_hell || hex !== exp_hex || wrap !== 1'b0) begin
            errors++;
            $display("FAIL blink_exit hex=%h wrap=%b expected hex=%h wrap=0", hex, wrap, w_hell);
        end
    endtask

    task automatic test_load_tick();
        apply_reset();
        mode = 2'b01; enable = 1'b1;
        for (int i = 1; i <= 4; i++) clk_step();
        load = 1'b1; load_index = 3'd1; load_char = 3'b011;
        clk_step();
        load = 1'b0;
        clk_step();
        checks++;
        if (hex !== w_ollo || hex !== exp_hex) begin
            errors++;
            $display("FAIL load_with_tick hex=%h expected %h", hex, w_ollo);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        mode = 2'b01; enable = 1'b1;
        for (int i = 1; i <= 23; i++) begin
            if (i == 10) begin
                load = 1'b1; load_index = 3'd0; load_char = 3'b010;
            end else begin
                load = 1'b0;
            end
            clk_step();
        end
        load = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (hex !== 28'hFFFFFFF || wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async hex=%h wrap=%b expected hex=fffffff wrap=0", hex, wrap);
        end
        @(negedge clk);
        enable = 1'b0;
        rst = 1'b0;
        model_reset();
        clk_step();
        checks++;
        if (hex !== w_hell) begin
            errors++;
            $display("FAIL reset_mid_restore hex=%h expected %h", hex, w_hell);
        end
        for (int i = 1; i <= 10; i++) begin
            clk_step();
            checks++;
            if (hex !== w_hell || wrap !== 1'b0 || hex !== exp_hex) begin
                errors++;
                $display("FAIL disabled_hold cyc%0d hex=%h wrap=%b expected hex=%h wrap=0", i, hex, wrap, w_hell);
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        mode = 2'($urandom_range(0, 3));
        for (int i = 1; i <= 1500; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            load = ($urandom_range(0, 5) == 0);
            load_index = 3'($urandom_range(0, 7));
            load_char = 3'($urandom_range(0, 7));
            clk_step();
            checks++;
            if (hex !== exp_hex || wrap !== exp_wrap) begin
                errors++;
                $display("FAIL random cyc%0d hex=%h wrap=%b expected hex=%h wrap=%b", i, hex, wrap, exp_hex, exp_wrap);
            end
        end
        load = 1'b0;
    endtask

    initial begin
        w_hell = {S_H, S_E, S_L, S_L};
        w_ello = {S_E, S_L, S_L, S_O};
        w_llob = {S_L, S_L, S_O, S_B};
        w_bhel = {S_B, S_H, S_E, S_L};
        w_ollo = {S_O, S_L, S_L, S_O};
        model_reset();
        test_reset();
        test_scroll_left();
        test_scroll_right();
        test_blink();
        test_load_tick();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
